ballot_unit: RTL

BALLOT_UNIT -- requirements
Module: ballot_unit

---
 rtl/ballot_pkg.sv | 39 +++
 rtl/ballot_debounce.sv | 45 ++++
 rtl/ballot_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ballot_pkg.sv
// Shared types, default parameters and press-decoding helpers for the ballot unit.
package ballot_pkg;

    localparam int unsigned NUM_BTN             = 4;
    localparam int unsigned IDX_W               = 2;
    localparam int unsigned CNT_W               = 3;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
    localparam int unsigned ARM_TIMEOUT_DEF     = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAST    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Number of debounced buttons currently held.
    function automatic logic [CNT_W-1:0] press_count(input logic [NUM_BTN-1:0] db);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            n = n + CNT_W'(db[i]);
        end
        return n;
    endfunction

    // Index of the held button; only meaningful when exactly one is held.
    function automatic logic [IDX_W-1:0] press_index(input logic [NUM_BTN-1:0] db);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            if (db[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ballot_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer for one button.
module ballot_debounce
    import ballot_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Adopt the new level once CYCLES consecutive samples disagree with the current one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CW'(CYCLES - 1)) begin
            level <= sync2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ballot_unit.sv
// Ballot unit: debounces four candidate buttons and issues at most one vote per arm.
module ballot_unit
    import ballot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned ARM_TIMEOUT     = ARM_TIMEOUT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic mode,
    input  logic arm,
    input  logic btn1,
    input  logic btn2,
    input  logic btn3,
    input  logic btn4,
    output logic vv1,
    output logic vv2,
    output logic vv3,
    output logic vv4,
    output logic ready,
    output logic invalid,
    output logic timeout
);

    localparam int unsigned     DW         = $clog2(ARM_TIMEOUT + 1);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(ARM_TIMEOUT - 1);
    localparam logic [DW-1:0]   DWELL_MAX  = DW'(ARM_TIMEOUT);

    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] db;
    logic [CNT_W-1:0]   n_press;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   next_idx;
    logic               after_invalid;
    logic               next_after_invalid;
    logic [DW-1:0]      dwell;
    logic [NUM_BTN-1:0] vv;
    logic [NUM_BTN-1:0] next_vv;
    logic               next_invalid;
    logic               next_timeout;

    assign raw = {btn4, btn3, btn2, btn1};

    for (genvar g = 0; g < int'(NUM_BTN); g++) begin : g_btn
        ballot_debounce #(
            .CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock(clock),
            .reset(reset),
            .raw  (raw[g]),
            .level(db[g])
        );
    end

    // State register and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            after_invalid <= 1'b0;
            vv            <= '0;
            ready         <= 1'b0;
            invalid       <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= next_state;
            idx           <= next_idx;
            after_invalid <= next_after_invalid;
            vv            <= next_vv;
            ready         <= (next_state == ST_ARMED);
            invalid       <= next_invalid;
            timeout       <= next_timeout;
        end
    end

    // ARMED dwell counter: cleared outside ARMED, saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dwell <= '0;
        end else if (state != ST_ARMED) begin
            dwell <= '0;
        end else if (dwell != DWELL_MAX) begin
            dwell <= dwell + DW'(1);
        end
    end

    // Next-state and output decode; mode overrides everything, a press beats expiry.
    always_comb begin
        next_state         = state;
        next_idx           = idx;
        next_after_invalid = after_invalid;
        next_invalid       = 1'b0;
        next_timeout       = 1'b0;
        next_vv            = '0;
        n_press            = press_count(db);

        if (mode) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm && (n_press == '0)) begin
                        next_state = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (n_press == CNT_W'(1)) begin
                        next_state         = ST_CAST;
                        next_idx           = press_index(db);
                        next_after_invalid = 1'b0;
                    end else if (n_press >= CNT_W'(2)) begin
                        next_state         = ST_RELEASE;
                        next_after_invalid = 1'b1;
                        next_invalid       = 1'b1;
                    end else if (dwell == DWELL_LAST) begin
                        next_state   = ST_IDLE;
                        next_timeout = 1'b1;
                    end
                end
                ST_CAST: begin
                    next_state = ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (n_press == '0) begin
                        next_state = after_invalid ? ST_ARMED : ST_IDLE;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end

        if (next_state == ST_CAST) begin
            next_vv = NUM_BTN'(1) << next_idx;
        end
    end

    assign vv1 = vv[0];
    assign vv2 = vv[1];
    assign vv3 = vv[2];
    assign vv4 = vv[3];

endmodule
